// File: rtl/tanimoto_batch_ctrl_if.sv
// tanimoto_batch_ctrl_if: start/threshold/BRAM/data-gate/ID-pair signals of the batch sequencer.
// o_PairCount is present only when TANIMOTO_CTRL_PAIR_CNT_EN is defined.
interface tanimoto_batch_ctrl_if #(
  parameter int VEC_ID_WIDTH = 8,
  parameter int CNT_WIDTH = 10
);
  logic i_Start;
  logic [VEC_ID_WIDTH:0] i_VecCount;
  logic [CNT_WIDTH:0] S_AXIS_THR_tdata;
  logic S_AXIS_THR_tvalid;
  logic S_AXIS_THR_tready;
  logic [CNT_WIDTH-1:0] o_BRAM_Addr;
  logic [CNT_WIDTH:0] o_BRAM_Din;
  logic o_BRAM_En;
  logic o_BRAM_WrEn;
  logic i_Data_tvalid;
  logic o_Data_tready;
  logic o_Data_tvalid;
  logic i_Data_tready;
  logic i_IDPair_Valid;
  logic i_IDPair_Ready;
  logic o_Busy;
  logic o_Done;
`ifdef TANIMOTO_CTRL_PAIR_CNT_EN
  logic [15:0] o_PairCount;
`endif
  modport master(
`ifdef TANIMOTO_CTRL_PAIR_CNT_EN
    input o_PairCount,
`endif
    output i_Start, i_VecCount, S_AXIS_THR_tdata, S_AXIS_THR_tvalid, i_Data_tvalid, i_Data_tready,
    output i_IDPair_Valid, i_IDPair_Ready,
    input S_AXIS_THR_tready, o_BRAM_Addr, o_BRAM_Din, o_BRAM_En, o_BRAM_WrEn,
    input o_Data_tready, o_Data_tvalid, o_Busy, o_Done
  );
  modport slave(
`ifdef TANIMOTO_CTRL_PAIR_CNT_EN
    output o_PairCount,
`endif
    input i_Start, i_VecCount, S_AXIS_THR_tdata, S_AXIS_THR_tvalid, i_Data_tvalid, i_Data_tready,
    input i_IDPair_Valid, i_IDPair_Ready,
    output S_AXIS_THR_tready, o_BRAM_Addr, o_BRAM_Din, o_BRAM_En, o_BRAM_WrEn,
    output o_Data_tready, o_Data_tvalid, o_Busy, o_Done
  );
endinterface

// File: rtl/tanimoto_batch_ctrl.sv
// tanimoto_batch_ctrl: loads the threshold table, gates one batch of data beats, waits for ID pairs to drain.
// Define TANIMOTO_CTRL_PAIR_CNT_EN to add the o_PairCount pair counter.
module tanimoto_batch_ctrl #(
  parameter int VECTOR_WIDTH = 920,
  parameter int BUS_WIDTH = 512,
  parameter int VEC_ID_WIDTH = 8,
  parameter int DRAIN_CYCLES = 64,
  parameter int CNT_WIDTH = $clog2(VECTOR_WIDTH),
  parameter int BEATS_PER_VEC = (VECTOR_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH
) (
  input logic ap_clk,
  input logic ap_rst,
  tanimoto_batch_ctrl_if.slave bus
);
  localparam int BEAT_W = VEC_ID_WIDTH + 1 + $clog2(BEATS_PER_VEC) + 1;
  localparam int IDLE_W = $clog2(DRAIN_CYCLES) + 1;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;
  state_t state;
  logic [VEC_ID_WIDTH:0] vec_cnt;
  logic [CNT_WIDTH:0] ld_cnt;
  logic [BEAT_W-1:0] beat_cnt, beat_total;
  logic [IDLE_W-1:0] idle_cnt;
  logic thr_rdy, gate, thr_acc, data_hs;
  assign beat_total = BEAT_W'(vec_cnt) * BEAT_W'(BEATS_PER_VEC);
  assign thr_acc = thr_rdy & bus.S_AXIS_THR_tvalid;
  assign data_hs = gate & bus.i_Data_tvalid & bus.i_Data_tready;
  assign bus.S_AXIS_THR_tready = thr_rdy;
  assign bus.o_Data_tvalid = gate & bus.i_Data_tvalid;
  assign bus.o_Data_tready = gate & bus.i_Data_tready;
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state <= IDLE;
      vec_cnt <= '0;
      ld_cnt <= '0;
      beat_cnt <= '0;
      idle_cnt <= '0;
      thr_rdy <= 1'b0;
      gate <= 1'b0;
      bus.o_BRAM_Addr <= '0;
      bus.o_BRAM_Din <= '0;
      bus.o_BRAM_En <= 1'b0;
      bus.o_BRAM_WrEn <= 1'b0;
      bus.o_Busy <= 1'b0;
      bus.o_Done <= 1'b0;
    end else begin
      bus.o_BRAM_En <= thr_acc;
      bus.o_BRAM_WrEn <= thr_acc;
      if (thr_acc) begin
        bus.o_BRAM_Addr <= ld_cnt[CNT_WIDTH-1:0];
        bus.o_BRAM_Din <= bus.S_AXIS_THR_tdata;
      end
      bus.o_Done <= 1'b0;
      case (state)
        IDLE: if (bus.i_Start) begin
          vec_cnt <= bus.i_VecCount;
          ld_cnt <= '0;
          beat_cnt <= '0;
          idle_cnt <= '0;
          thr_rdy <= 1'b1;
          bus.o_Busy <= 1'b1;
          state <= LOAD;
        end
        LOAD: if (thr_acc) begin
          ld_cnt <= ld_cnt + 1'b1;
          if (ld_cnt == (CNT_WIDTH+1)'(VECTOR_WIDTH)) begin
            thr_rdy <= 1'b0;
            gate <= vec_cnt != '0;
            state <= vec_cnt != '0 ? RUN : DRAIN;
          end
        end
        RUN: if (data_hs) begin
          beat_cnt <= beat_cnt + 1'b1;
          if (beat_cnt + 1'b1 == beat_total) begin
            gate <= 1'b0;
            state <= DRAIN;
          end
        end
        // a pair on the final idle-count cycle wins: counter clears, no transition
        DRAIN: if (bus.i_IDPair_Valid) idle_cnt <= '0;
          else if (idle_cnt == IDLE_W'(DRAIN_CYCLES - 1)) begin
            bus.o_Done <= 1'b1;
            state <= DONE;
          end else idle_cnt <= &idle_cnt ? idle_cnt : idle_cnt + 1'b1;
        DONE: begin
          bus.o_Busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef TANIMOTO_CTRL_PAIR_CNT_EN
  always_ff @(posedge ap_clk) begin
    if (ap_rst || (state == IDLE && bus.i_Start)) bus.o_PairCount <= '0;
    else if ((state == RUN || state == DRAIN) && bus.i_IDPair_Valid && bus.i_IDPair_Ready && !(&bus.o_PairCount))
      bus.o_PairCount <= bus.o_PairCount + 1'b1;
  end
`else
  logic unused_pair_ready;
  assign unused_pair_ready = bus.i_IDPair_Ready;
`endif
endmodule

// File: tb/tb_tanimoto_batch_ctrl.sv
// tb_tanimoto_batch_ctrl: table of batch scenarios plus drain-timing and mid-run reset sequences;
// BRAM writes are checked against a queue of expected {addr, data} filled as threshold beats are accepted.
`timescale 1ns/1ps
module tb_tanimoto_batch_ctrl;
  localparam int VW = 920;
  localparam int CW = $clog2(VW);
  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  always #5 ap_clk = ~ap_clk;
  tanimoto_batch_ctrl_if #(.VEC_ID_WIDTH(8), .CNT_WIDTH(CW)) bus();
  tanimoto_batch_ctrl dut (.ap_clk(ap_clk), .ap_rst(ap_rst), .bus(bus));
  typedef struct {
    int vec;
    int offer;
    bit thr_rand;
    int hs;
  } batch_t;
  batch_t tbl[5];
  logic [2*CW:0] exp_q[$];
  int n_cmp = 0, n_bad = 0, ld_addr, n_wr, n_hs, n_up, n_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    logic [2*CW:0] e;
    #1;
    if (!ap_rst && bus.S_AXIS_THR_tready && bus.S_AXIS_THR_tvalid) begin
      exp_q.push_back({ld_addr[CW-1:0], bus.S_AXIS_THR_tdata});
      ld_addr++;
    end
    if (!ap_rst && bus.o_Data_tvalid && bus.i_Data_tready) n_hs++;
    if (!ap_rst && bus.i_Data_tvalid && bus.o_Data_tready) n_up++;
    @(posedge ap_clk);
    #1;
    if (bus.o_Done) n_done++;
    if (bus.o_BRAM_En) begin
      n_wr++;
      e = exp_q.size() != 0 ? exp_q.pop_front() : '1;
      chk("bram_write", {bus.o_BRAM_WrEn, bus.o_BRAM_Addr, bus.o_BRAM_Din}, {1'b1, e});
    end else if (exp_q.size() != 0) begin
      chk("bram_write_latency", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic start_and_load(input int vec, input bit rnd);
    chk("idle_before_start", {bus.o_Busy, bus.S_AXIS_THR_tready}, 0);
    ld_addr = 0; n_wr = 0; n_hs = 0; n_up = 0; n_done = 0;
    bus.i_Start = 1'b1;
    bus.i_VecCount = 9'(vec);
    tick();
    bus.i_Start = 1'b0;
    bus.i_VecCount = 9'($urandom);
    chk("load_busy_tready", {bus.o_Busy, bus.S_AXIS_THR_tready}, 2'b11);
    for (int c = 0; c < 4000 && ld_addr <= VW; c++) begin
      bus.S_AXIS_THR_tvalid = rnd ? 1'($urandom) : 1'b1;
      bus.S_AXIS_THR_tdata = rnd ? (CW+1)'($urandom) : (CW+1)'(ld_addr);
      tick();
    end
    chk("thr_tready_drop", bus.S_AXIS_THR_tready, 0);
    bus.S_AXIS_THR_tvalid = 1'b1;
    repeat (3) tick();
    bus.S_AXIS_THR_tvalid = 1'b0;
    chk("thr_write_count", n_wr, VW + 1);
  endtask

  task automatic run_data(input int offer, input int hs_exp);
    bit closed = 1'b0;
    for (int c = 0; c < 3 * offer + 8; c++) begin
      bus.i_Data_tvalid = n_up < offer;
      bus.i_Data_tready = (c % 3) != 2;
      tick();
      if (hs_exp > 0 && n_hs == hs_exp && !closed) begin
        closed = 1'b1;
        bus.i_Data_tvalid = 1'b1;
        bus.i_Data_tready = 1'b1;
        #1;
        chk("gate_closed", {bus.o_Data_tvalid, bus.o_Data_tready}, 0);
      end
    end
    bus.i_Data_tvalid = 1'b0;
    bus.i_Data_tready = 1'b0;
    chk("data_handshakes", n_hs, hs_exp);
    chk("upstream_beats", n_up, hs_exp);
  endtask

  task automatic wait_done(input int exp_lat);
    int c = 0;
    while (!bus.o_Done && c < 300) begin
      tick();
      c++;
    end
    chk("done_seen", bus.o_Done, 1);
    if (exp_lat >= 0) chk("done_latency", c, exp_lat);
    chk("busy_in_done", bus.o_Busy, 1);
    bus.i_Start = 1'b1;
    tick();
    bus.i_Start = 1'b0;
    chk("after_done", {bus.o_Done, bus.o_Busy, bus.S_AXIS_THR_tready}, 0);
    chk("done_pulses", n_done, 1);
  endtask

  initial begin
    tbl[0] = '{4, 12, 1'b0, 8};
    tbl[1] = '{4, 12, 1'b1, 8};
    tbl[2] = '{0, 4, 1'b0, 0};
    tbl[3] = '{1, 5, 1'b1, 2};
    tbl[4] = '{3, 6, 1'b0, 6};
    bus.i_Start = 1'b0;
    bus.i_VecCount = '0;
    bus.S_AXIS_THR_tdata = '0;
    bus.S_AXIS_THR_tvalid = 1'b0;
    bus.i_Data_tvalid = 1'b0;
    bus.i_Data_tready = 1'b0;
    bus.i_IDPair_Valid = 1'b0;
    bus.i_IDPair_Ready = 1'b0;
    @(posedge ap_clk);
    #1;
    repeat (3) tick();
    chk("reset_outputs", {bus.o_Busy, bus.o_Done, bus.S_AXIS_THR_tready, bus.o_BRAM_En, bus.o_BRAM_WrEn,
                          bus.o_BRAM_Addr, bus.o_BRAM_Din, bus.o_Data_tvalid, bus.o_Data_tready}, 0);
    ap_rst = 1'b0;
    tick();
    foreach (tbl[i]) begin
      start_and_load(tbl[i].vec, tbl[i].thr_rand);
      run_data(tbl[i].offer, tbl[i].hs);
      wait_done(-1);
    end
    // drain timing: pairs during DRAIN restart the idle count; done follows 64 idle cycles after the last
    start_and_load(1, 1'b0);
    run_data(2, 2);
    for (int c = 0; c <= 50; c++) begin
      bus.i_IDPair_Valid = c == 10 || c == 30 || c == 50;
      bus.i_IDPair_Ready = c != 30;
      tick();
    end
    bus.i_IDPair_Valid = 1'b0;
    bus.i_IDPair_Ready = 1'b0;
    chk("no_early_done", n_done, 0);
    wait_done(64);
`ifdef TANIMOTO_CTRL_PAIR_CNT_EN
    chk("pair_count", bus.o_PairCount, 2);
`endif
    // reset in the middle of RUN, then a fresh batch must reload from address 0
    start_and_load(4, 1'b0);
    bus.i_Data_tvalid = 1'b1;
    bus.i_Data_tready = 1'b1;
    for (int c = 0; c < 20 && n_hs < 3; c++) tick();
    chk("hs_before_reset", n_hs, 3);
    ap_rst = 1'b1;
    tick();
    #1;
    chk("midrun_reset_outputs", {bus.o_Busy, bus.o_Done, bus.S_AXIS_THR_tready, bus.o_BRAM_En, bus.o_BRAM_WrEn,
                                 bus.o_BRAM_Addr, bus.o_BRAM_Din, bus.o_Data_tvalid, bus.o_Data_tready}, 0);
    ap_rst = 1'b0;
    bus.i_Data_tvalid = 1'b0;
    bus.i_Data_tready = 1'b0;
    tick();
    start_and_load(1, 1'b1);
    run_data(2, 2);
    wait_done(-1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
